lcd_sprite_blit: RTL and testbench

Parametrised successor to the single-sprite LCD run engine. Accepts one sprite-draw command per valid/ready handshake and sets the panel window with column/page address commands. It then streams W×H pixels from an external synchronous ROM over the 8080-style parallel LCD bus. It sits between the game-logic sprite scheduler and the LCD pins, replacing the hard-coded picture case table with command fields (base address, size, position), and adds rejection of off-panel windows, done/error pulses and optional horizontal mirroring.

---
 rtl/lcd_sprite_blit.sv | 212 +++++++++++++++++++++
 tb/tb_lcd_sprite_blit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_sprite_blit.sv
// Sprite blitter: per command, programs the panel column/page window, then streams W x H
// pixels from an external ROM onto an 8080-style LCD bus. Define LCD_SPRITE_BLIT_MIRROR_EN for horizontal mirroring.
module lcd_sprite_blit #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16,
  parameter int X_WIDTH    = 8,
  parameter int Y_WIDTH    = 9,
  parameter int X_MAX      = 239,
  parameter int Y_MAX      = 319
) (
  input  logic                  clk,
  input  logic                  rstn,
  // valid/ready: a command transfers on a rising edge where cmd_valid && cmd_ready are both high;
  // cmd_ready is high only while idle, and cmd_valid is ignored at all other times.
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [X_WIDTH-1:0]    cmd_x,
  input  logic [Y_WIDTH-1:0]    cmd_y,
  input  logic [X_WIDTH-1:0]    cmd_w_m1,
  input  logic [Y_WIDTH-1:0]    cmd_h_m1,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic                  cmd_mirror,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  LCD_CS,
  output logic                  LCD_RS,
  output logic                  LCD_WR,
  output logic                  LCD_RD,
  output logic [DATA_WIDTH-1:0] LCD_DATA,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {IDLE, CHECK, ADDR, PIX, FIN} state_t;

  localparam logic [X_WIDTH:0] XE_LIM = (X_WIDTH+1)'(X_MAX);
  localparam logic [Y_WIDTH:0] YE_LIM = (Y_WIDTH+1)'(Y_MAX);

  state_t                state, state_nxt;
  logic                  rdy_en;
  logic                  phase;
  logic [3:0]            widx, nidx;
  logic [X_WIDTH-1:0]    x_q, w_q, col, col_nxt, offset;
  logic [Y_WIDTH-1:0]    y_q, h_q, row;
  logic [ADDR_WIDTH-1:0] base_q, row_start, row_start_nxt, stride, first_addr;
  logic [X_WIDTH:0]      xe;
  logic [Y_WIDTH:0]      ye;
  logic [15:0]           xs16, xe16, ys16, ye16;
  logic [7:0]            addr_byte;
  logic                  bad, eol, last_pix, accept;

  assign accept    = cmd_valid && cmd_ready;
  assign cmd_ready = (state == IDLE) && rdy_en;
  assign state_dbg = state;
  assign LCD_RD    = 1'b1;
  assign LCD_CS    = !((state == ADDR) || (state == PIX));
  assign LCD_WR    = !(((state == ADDR) || (state == PIX)) && !phase);
  // Commands 0x2A/0x2B/0x2C sit at write slots 0, 5 and 10 and go out with RS low.
  assign LCD_RS    = !((state == ADDR) && ((widx == 4'd0) || (widx == 4'd5) || (widx == 4'd10)));

  assign xe   = {1'b0, x_q} + {1'b0, w_q};
  assign ye   = {1'b0, y_q} + {1'b0, h_q};
  assign bad  = (xe > XE_LIM) || (ye > YE_LIM);
  assign xs16 = 16'(x_q);
  assign xe16 = 16'(xe);
  assign ys16 = 16'(y_q);
  assign ye16 = 16'(ye);

  assign nidx = (state == ADDR) ? widx + 4'd1 : 4'd0;

  always_comb begin
    addr_byte = 8'h00;
    case (nidx)
      4'd0:    addr_byte = 8'h2A;
      4'd1:    addr_byte = xs16[15:8];
      4'd2:    addr_byte = xs16[7:0];
      4'd3:    addr_byte = xe16[15:8];
      4'd4:    addr_byte = xe16[7:0];
      4'd5:    addr_byte = 8'h2B;
      4'd6:    addr_byte = ys16[15:8];
      4'd7:    addr_byte = ys16[7:0];
      4'd8:    addr_byte = ye16[15:8];
      4'd9:    addr_byte = ye16[7:0];
      4'd10:   addr_byte = 8'h2C;
      default: addr_byte = 8'h00;
    endcase
  end

  // Pixel addressing: row-start accumulator plus column counter; wraps modulo 2^ADDR_WIDTH.
  assign stride        = ADDR_WIDTH'(w_q) + ADDR_WIDTH'(1);
  assign eol           = (col == w_q);
  assign last_pix      = eol && (row == h_q);
  assign col_nxt       = eol ? '0 : col + X_WIDTH'(1);
  assign row_start_nxt = eol ? row_start + stride : row_start;

`ifdef LCD_SPRITE_BLIT_MIRROR_EN
  logic mir_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      mir_q <= 1'b0;
    else if (state == IDLE && accept)
      mir_q <= cmd_mirror;
  end

  assign offset     = mir_q ? (w_q - col_nxt) : col_nxt;
  assign first_addr = mir_q ? base_q + ADDR_WIDTH'(w_q) : base_q;
`else
  logic unused_mirror;
  assign unused_mirror = cmd_mirror;
  assign offset        = col_nxt;
  assign first_addr    = base_q;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = CHECK;
      end
      CHECK: begin
        err       = bad;
        state_nxt = bad ? IDLE : ADDR;
      end
      ADDR:    if (phase && widx == 4'd10) state_nxt = PIX;
      PIX:     if (phase && last_pix) state_nxt = FIN;
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      base_q    <= '0;
      phase     <= 1'b0;
      widx      <= '0;
      col       <= '0;
      row       <= '0;
      row_start <= '0;
      rom_addr  <= '0;
      LCD_DATA  <= '0;
    end else begin
      case (state)
        IDLE: begin
          phase <= 1'b0;
          widx  <= '0;
          if (accept) begin
            x_q    <= cmd_x;
            y_q    <= cmd_y;
            w_q    <= cmd_w_m1;
            h_q    <= cmd_h_m1;
            base_q <= cmd_base;
          end
        end
        CHECK: if (!bad) LCD_DATA <= DATA_WIDTH'(addr_byte);
        ADDR: begin
          phase <= ~phase;
          if (!phase) begin
            // First pixel address goes out during the second half of the 0x2C write.
            if (widx == 4'd10) begin
              rom_addr  <= first_addr;
              row_start <= base_q;
              col       <= '0;
              row       <= '0;
            end
          end else if (widx == 4'd10) begin
            LCD_DATA <= rom_data;
          end else begin
            LCD_DATA <= DATA_WIDTH'(addr_byte);
            widx     <= widx + 4'd1;
          end
        end
        PIX: begin
          phase <= ~phase;
          if (!phase) begin
            if (!last_pix) rom_addr <= row_start_nxt + ADDR_WIDTH'(offset);
          end else if (!last_pix) begin
            LCD_DATA  <= rom_data;
            col       <= col_nxt;
            row_start <= row_start_nxt;
            if (eol) row <= row + Y_WIDTH'(1);
          end
        end
        default: phase <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_sprite_blit.sv
// Bench for lcd_sprite_blit: random and directed sprite commands, an arithmetic reference model
// feeding expected queues, and a negedge monitor that checks every bus write, done and err pulse.
module tb_lcd_sprite_blit;
  localparam int AW = 17;
  localparam int DW = 16;
  localparam int XW = 8;
  localparam int YW = 9;

`ifdef LCD_SPRITE_BLIT_MIRROR_EN
  localparam bit MIRROR_EN = 1'b1;
`else
  localparam bit MIRROR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_mirror;
  logic [XW-1:0] cmd_x, cmd_w_m1;
  logic [YW-1:0] cmd_y, cmd_h_m1;
  logic [AW-1:0] cmd_base, rom_addr;
  logic [DW-1:0] rom_data, LCD_DATA;
  logic          busy, done, err, LCD_CS, LCD_RS, LCD_WR, LCD_RD;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_idx   = 0;

  logic [DW:0]   exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            exp_done_q[$];
  int            exp_err_q[$];
  logic [DW:0]   exp_w;

  lcd_sprite_blit dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w_m1(cmd_w_m1), .cmd_h_m1(cmd_h_m1),
    .cmd_base(cmd_base), .cmd_mirror(cmd_mirror),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .done(done), .err(err),
    .LCD_CS(LCD_CS), .LCD_RS(LCD_RS), .LCD_WR(LCD_WR), .LCD_RD(LCD_RD),
    .LCD_DATA(LCD_DATA), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM contents are a fixed scramble of the address; read data is sampled one cycle after issue.
  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[15:0] ^ {a[16], 15'h2D5B};
  endfunction
  assign rom_data = rom_fn(rom_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected nothing (cycle %0d)", name, act, cyc);
  endtask

  // Reference model: window bounds, the 11 setup words and the pixel address list.
  task automatic model_cmd(input int t, input int x, input int y, input int w, input int h,
                           input int base, input logic mir, output int t_end);
    int   wd[11];
    int   col;
    logic rs;
    logic [AW-1:0] a;
    if (x + w > 239 || y + h > 319) begin
      exp_err_q.push_back(t + 1);
      t_end = t + 1;
      return;
    end
    wd = '{'h2A, x / 256, x % 256, (x + w) / 256, (x + w) % 256,
           'h2B, y / 256, y % 256, (y + h) / 256, (y + h) % 256, 'h2C};
    for (int i = 0; i < 11; i++) begin
      rs = !(i == 0 || i == 5 || i == 10);
      exp_q.push_back({rs, DW'(wd[i])});
    end
    for (int r = 0; r <= h; r++) begin
      for (int c = 0; c <= w; c++) begin
        col = (MIRROR_EN && mir) ? w - c : c;
        a   = AW'(base + r * (w + 1) + col);
        exp_addr_q.push_back(a);
        exp_q.push_back({1'b1, rom_fn(a)});
      end
    end
    t_end = t + 24 + 2 * (w + 1) * (h + 1);
    exp_done_q.push_back(t_end);
  endtask

  // driver: present a command, wait for the handshake, then scramble or hold the inputs
  task automatic send_cmd(input int x, input int y, input int w, input int h, input int base,
                          input logic mir, input bit hold, output int t, output int t_end);
    int guard = 0;
    cmd_valid  = 1'b1;
    cmd_x      = XW'(x);
    cmd_y      = YW'(y);
    cmd_w_m1   = XW'(w);
    cmd_h_m1   = YW'(h);
    cmd_base   = AW'(base);
    cmd_mirror = mir;
    @(negedge clk);
    while (!cmd_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    t = cyc;
    t_end = cyc;
    if (!cmd_ready) begin
      check("handshake_timeout", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    model_cmd(t, x, y, w, h, base, mir, t_end);
    @(posedge clk);
    #1;
    if (!hold) begin
      cmd_valid  = 1'b0;
      cmd_x      = XW'($urandom);
      cmd_y      = YW'($urandom);
      cmd_w_m1   = XW'($urandom);
      cmd_h_m1   = YW'($urandom);
      cmd_base   = AW'($urandom);
      cmd_mirror = 1'($urandom);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || exp_q.size() != 0 || exp_done_q.size() != 0 || exp_err_q.size() != 0)
           && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_idle", {busy, 1'(exp_q.size() != 0), 1'(exp_done_q.size() != 0),
                         1'(exp_err_q.size() != 0)}, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_cs"}, LCD_CS, 1);
    check({tag, "_wr"}, LCD_WR, 1);
    check({tag, "_rs"}, LCD_RS, 1);
    check({tag, "_rd"}, LCD_RD, 1);
    check({tag, "_data"}, LCD_DATA, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rstn || LCD_CS) wr_idx = 0;
    if (rstn) begin
      if (!LCD_CS && !LCD_WR) begin
        if (exp_q.size() == 0) begin
          unexpected("bus_write_extra", {LCD_RS, LCD_DATA});
        end else begin
          exp_w = exp_q.pop_front();
          check(wr_idx < 11 ? "addr_write" : "pixel_write", {LCD_RS, LCD_DATA}, exp_w);
          if (wr_idx >= 11) begin
            if (exp_addr_q.size() == 0) unexpected("rom_addr_extra", rom_addr);
            else check("rom_addr", rom_addr, exp_addr_q.pop_front());
          end
        end
        wr_idx++;
      end
      if (done) begin
        if (exp_done_q.size() == 0) unexpected("done_extra", cyc);
        else check("done_cycle", cyc, exp_done_q.pop_front());
        check("done_busy", busy, 1);
      end
      if (err) begin
        if (exp_err_q.size() == 0) unexpected("err_extra", cyc);
        else check("err_cycle", cyc, exp_err_q.pop_front());
        check("err_cs_high", LCD_CS, 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, te, t2, te2;
    cmd_valid  = 1'b0;
    cmd_x      = '0;
    cmd_y      = '0;
    cmd_w_m1   = '0;
    cmd_h_m1   = '0;
    cmd_base   = '0;
    cmd_mirror = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);
    @(posedge clk);
    #1;

    // basic 2x2 window, then mirrored
    send_cmd(10, 20, 1, 1, 100, 1'b0, 1'b0, t, te);
    wait_idle();
    send_cmd(10, 20, 1, 1, 100, 1'b1, 1'b0, t, te);
    wait_idle();

    // off-panel window is rejected; ready returns two cycles after the handshake
    send_cmd(230, 0, 10, 0, 500, 1'b0, 1'b0, t, te);
    while (cyc < t + 2) @(negedge clk);
    check("ready_after_err", cmd_ready, 1);
    wait_idle();
    send_cmd(0, 300, 0, 20, 500, 1'b0, 1'b0, t, te);
    wait_idle();

    // last legal pixel, and address wrap
    send_cmd(239, 319, 0, 0, 'h1FFFF, 1'b0, 1'b0, t, te);
    wait_idle();
    send_cmd(0, 0, 3, 2, 'h1FFFA, 1'b1, 1'b0, t, te);
    wait_idle();

    // back-to-back: second command waits for the cycle after done
    send_cmd(5, 6, 2, 1, 300, 1'b1, 1'b1, t, te);
    send_cmd(50, 60, 0, 2, 7000, 1'b0, 1'b0, t2, te2);
    check("b2b_accept_cycle", t2, te + 1);
    wait_idle();

    for (int i = 0; i < 14; i++) begin
      send_cmd($urandom_range(0, 255), $urandom_range(0, 340), $urandom_range(0, 12),
               $urandom_range(0, 5), $urandom_range(0, 131071), 1'($urandom_range(0, 1)),
               1'b0, t, te);
      wait_idle();
    end

    // asynchronous reset in the middle of the pixel stream
    send_cmd(0, 0, 7, 7, 1000, 1'b0, 1'b0, t, te);
    while (cyc < t + 33) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_vals("midrst");
    exp_q.delete();
    exp_addr_q.delete();
    exp_done_q.delete();
    exp_err_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_midrst", cmd_ready, 1);
    @(posedge clk);
    #1;
    send_cmd(100, 200, 4, 3, 2000, 1'b1, 1'b0, t, te);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
